breath_led_scheduler: RTL
=========================

// Module: breath_led_scheduler
// PURPOSE
//   Time-shares one BreathLed generator between N_CH front-panel LEDs (run, lap, alarm, ...).
//   Requesters raise req[i]; the scheduler grants one channel at a time, round-robin.
//   For each grant it drives the generator's enable and routes the generator's led output to that channel.
//   Sits between the stopwatch status logic and a single BreathLed instance.
// PARAMETERS
//   N_CH        4           number of LED channels (2..8)
//   SLOT_CYCLES 50_000_000  cycles a channel holds the grant (1 s at 50 MHz), >= 2
//   GAP_CYCLES  50_000      cycles breath_en is held low between grants, so the generator restarts its ramp; >= 1
// PORTS
//   CLK_50MHz  in   1     system clock, 50 MHz
//   reset_n    in   1     asynchronous active-low reset
//   req        in   N_CH  per-channel breathing request, level; bit i = channel i
//   pause      in   1     freeze: deassert breath_en, hold dwell counter and grant
//   led_in     in   1     led output of the shared BreathLed
//   breath_en  out  1     enable to the shared BreathLed
//   grant      out  N_CH  one-hot granted channel, all-zero when none
//   led_out    out  N_CH  per-channel LED drive
//   busy       out  1     high in GRANT or GAP
// BEHAVIOUR
//   Reset (async, reset_n=0)
//     state=IDLE; breath_en=0; grant=0; busy=0; led_out=0.
//     Dwell counter and gap counter cleared; rr pointer=0.
//   All state changes occur on the CLK_50MHz rising edge.
//   Counters are $clog2(max(SLOT_CYCLES,GAP_CYCLES))+1 bits wide, unsigned, and never wrap.
//   IDLE
//     Stays while req==0.
//     Otherwise selects the first set req bit at or after rr pointer, wrapping N_CH-1 -> 0.
//     Next cycle: state=GRANT; grant=onehot(sel); breath_en=1; dwell counter=0.
//   GRANT
//     Dwell counter increments each cycle while pause=0.
//     When the counter reaches SLOT_CYCLES-1, or when req[granted] samples 0 (early release):
//       next state=GAP; grant=0; breath_en=0; gap counter=0; rr pointer=granted+1 mod N_CH.
//   GAP
//     Gap counter increments each cycle; pause has no effect.
//     When the gap counter reaches GAP_CYCLES-1:
//       next state is IDLE; arbitration happens in IDLE, so the next grant follows one cycle later.
//   pause=1 in GRANT
//     breath_en=0 combinationally gated; grant held; dwell counter held.
//     Releasing pause resumes breath_en the same cycle.
//   pause=1 in IDLE
//     No new grant is issued.
//   Registered outputs: breath_en and grant.
//   led_out is combinational: led_out[i] = grant[i] & led_in & breath_en. No extra latency.
//   Single requester: it is re-granted after every GAP, so a gap blink occurs every SLOT_CYCLES+GAP_CYCLES+1 cycles.
//   A req rising during GRANT or GAP waits; it is never pre-empted or lost while still high.
//   Simultaneous req drop and slot expiry: one transition to GAP.
//   grant is never multi-hot; breath_en=1 implies exactly one grant bit set.
// TESTING (bench: N_CH=4, SLOT_CYCLES=8, GAP_CYCLES=2, 20 ns clock)
//   1. reset_n low 40 ns with req=4'b1111:
//        all outputs 0. After release: grant=0001 one cycle later, breath_en=1.
//   2. req=4'b1111 held:
//        grant sequence 0001,0010,0100,1000,0001. Each held 8 cycles, 2+1 cycles zero between.
//   3. req=4'b0100 only:
//        grant=0100 repeatedly; breath_en low exactly 3 cycles between slots.
//   4. req[0] dropped at cycle 3 of its slot:
//        GAP next cycle; next grant goes to the lowest set bit after ch0.
//   5. pause high 5 cycles mid-slot:
//        breath_en=0, grant held; slot ends 5 cycles later than unpaused.
//   6. reset_n pulsed low mid-GRANT:
//        outputs 0 immediately (asynchronously); restart grants from channel 0.
//   Checkers
//     grant one-hot-or-zero; led_out==grant&{N_CH{led_in&breath_en}} every cycle.

Source files
------------

// File: rtl/breath_led_scheduler.sv
// Round-robin scheduler that time-shares one BreathLed generator between N_CH
// front-panel LEDs, with a dead gap between grants so the generator restarts.
module breath_led_scheduler #(
  parameter int N_CH        = 4,
  parameter int SLOT_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 50_000
) (
  input  logic            CLK_50MHz,
  input  logic            reset_n,
  input  logic [N_CH-1:0] req,
  input  logic            pause,
  input  logic            led_in,
  output logic            breath_en,
  output logic [N_CH-1:0] grant,
  output logic [N_CH-1:0] led_out,
  output logic            busy
);

  localparam int MAX_CYC = (SLOT_CYCLES > GAP_CYCLES) ? SLOT_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_CYC) + 1;
  localparam int PW      = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] CH_LAST   = PW'(N_CH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N_CH-1:0] grant_q, grant_d;
  logic [PW-1:0]   idx_q, idx_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic            en_q, en_d;
  logic [CW-1:0]   dwell_q, dwell_d;
  logic [CW-1:0]   gap_q, gap_d;

  logic            sel_found;
  logic [PW-1:0]   sel_idx;
  logic [PW-1:0]   rr_next;

  // Search starts at the rr pointer and wraps, so the last holder goes to the back
  always_comb begin
    int cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int k = 0; k < N_CH; k++) begin
      cand = int'(rr_q) + k;
      if (cand >= N_CH) cand = cand - N_CH;
      if (!sel_found && req[PW'(cand)]) begin
        sel_found = 1'b1;
        sel_idx   = PW'(cand);
      end
    end
  end

  assign rr_next = (idx_q == CH_LAST) ? '0 : idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    en_d    = en_q;
    dwell_d = dwell_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_found && !pause) begin
          state_d          = ST_GRANT;
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          idx_d            = sel_idx;
          en_d             = 1'b1;
          dwell_d          = '0;
        end
      end
      ST_GRANT: begin
        // A paused slot is fully frozen: no expiry and no early release
        if (!pause) begin
          if (dwell_q == SLOT_LAST || !req[idx_q]) begin
            state_d = ST_GAP;
            grant_d = '0;
            en_d    = 1'b0;
            gap_d   = '0;
            rr_d    = rr_next;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      rr_q    <= '0;
      en_q    <= 1'b0;
      dwell_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      en_q    <= en_d;
      dwell_q <= dwell_d;
      gap_q   <= gap_d;
    end
  end

  assign breath_en = en_q & ~pause;
  assign grant     = grant_q;
  assign led_out   = grant_q & {N_CH{led_in & breath_en}};
  assign busy      = (state_q != ST_IDLE);

endmodule
